// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: scoreboard RAW detection, multi-cycle EX sequencing and stall/flush counters.
// Define HAZARD_FORWARDING_EN when the forwarding network exists; RAW then reduces to load-use.
module pipeline_hazard_ctrl #(
  parameter int TRACK_DEPTH = 3,
  parameter int MC_LAT = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_multicycle,
  input  logic             ex_flush,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             id_ex_hold,
  output logic             ex_mem_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int CW = $clog2(MC_LAT);
  typedef enum logic {RUN, MC_BUSY} state_t;
  state_t state, state_n;
  logic [CW-1:0] mc_cnt, mc_cnt_n;
  logic [TRACK_DEPTH-1:0] sb_v;
  logic [4:0] sb_rd [TRACK_DEPTH];
  logic sb_ld;
  logic [TRACK_DEPTH-1:0] chk;
  logic rs1_hit, rs2_hit, raw, issue;
  logic unused_sb;
`ifdef HAZARD_FORWARDING_EN
  assign chk = TRACK_DEPTH'(sb_v[0] & sb_ld);
  assign unused_sb = ^sb_v;
`else
  assign chk = sb_v;
  assign unused_sb = sb_ld;
`endif
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int k = 0; k < TRACK_DEPTH; k++) begin
      rs1_hit = rs1_hit | (chk[k] & (sb_rd[k] == id_rs1));
      rs2_hit = rs2_hit | (chk[k] & (sb_rd[k] == id_rs2));
    end
  end
  assign raw = id_valid & ((id_rs1_used & (|id_rs1) & rs1_hit) | (id_rs2_used & (|id_rs2) & rs2_hit));
  // Busy dominates everything; a taken branch masks any RAW stall.
  assign busy = state == MC_BUSY;
  assign if_id_stall = busy | (~ex_flush & raw);
  assign if_id_flush = ~busy & ex_flush;
  assign id_ex_bubble = ~busy & (ex_flush | raw);
  assign id_ex_hold = busy;
  assign ex_mem_bubble = busy;
  assign issue = ~busy & id_valid & ~if_id_stall & ~id_ex_bubble;
  always_comb begin
    state_n = state;
    mc_cnt_n = mc_cnt;
    if (state == RUN) begin
      state_n = (issue & id_multicycle) ? MC_BUSY : RUN;
      mc_cnt_n = (issue & id_multicycle) ? CW'(MC_LAT - 1) : mc_cnt;
    end else begin
      mc_cnt_n = mc_cnt - CW'(1);
      state_n = (mc_cnt == CW'(1)) ? RUN : MC_BUSY;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      mc_cnt <= '0;
    end else begin
      state <= state_n;
      mc_cnt <= mc_cnt_n;
    end
  end
  // While busy the EX entry stays put and a hole moves into MEM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_v <= '0;
      sb_ld <= 1'b0;
      for (int k = 0; k < TRACK_DEPTH; k++) sb_rd[k] <= '0;
    end else begin
      if (!busy) begin
        sb_v[0] <= issue & id_reg_write & (|id_rd);
        sb_rd[0] <= id_rd;
        sb_ld <= id_mem_read;
      end
      for (int k = 1; k < TRACK_DEPTH; k++) begin
        sb_v[k] <= (busy && k == 1) ? 1'b0 : sb_v[k-1];
        sb_rd[k] <= sb_rd[k-1];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (if_id_stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule
